marks_row_reader: RTL
=====================

Name: marks_row_reader

Overview:
- Read-side counterpart to the per-section mark registers. On a start strobe it snapshots the full 19x19 board of marks and streams it out one section (row) per beat over a valid/ready handshake.
- Each beat carries the row index, a last flag and the number of set marks in that row.
- Sits between the board mark register bank and the stream interface toward the software partition / move evaluator.

Parameters:
- section_size, 19, bits per row (one mark bit per board point)
- num_rows, 19, rows per board
- idx_w, 5, width of row index; must satisfy 2^idx_w >= num_rows
- cnt_w, 5, width of per-row mark count; must satisfy 2^cnt_w > section_size

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a board readout; sampled only in IDLE
- board_in  input  num_rows*section_size  flattened board; row r occupies bits [r*section_size : r*section_size+section_size-1], bit 0 is MSB-side leftmost point
- busy  output  1  high from the cycle after start is accepted until the return to IDLE
- row_valid  output  1  current beat valid
- row_ready  input  1  downstream accepts beat
- row_data  output  [0:section_size-1]  marks of current row
- row_idx  output  idx_w  index of current row, 0..num_rows-1
- row_last  output  1  high with row_valid when row_idx == num_rows-1
- row_count  output  cnt_w  population count of row_data
- done  output  1  one-cycle pulse after the last beat is transferred

Behaviour:
- Reset: state=IDLE, snapshot=0, row index=0. All outputs are 0 in the cycle after rst is sampled high. rst overrides every other input.
- States: IDLE, SCAN, DONE.
- IDLE -> SCAN:
  - start=1 at edge T captures board_in into the snapshot register and clears the row index.
  - At T+1: busy=1, row_valid=1, row_idx=0.
  - Latency from start to first valid is 1 cycle.
- SCAN:
  - A transfer occurs on an edge where row_valid & row_ready.
  - On a transfer with index < num_rows-1, the index increments and the next row is presented in the following cycle. Back-to-back transfers sustain 1 row/cycle.
  - With row_valid=1 and row_ready=0, row_data, row_idx, row_last and row_count hold stable.
  - row_valid never drops before its transfer.
- SCAN -> DONE: on the transfer of row num_rows-1.
- DONE:
  - Lasts exactly one cycle: done=1, row_valid=0, busy=1.
  - Then returns to IDLE with busy=0.
- Snapshot isolation: changes on board_in after the start edge do not affect any streamed beat.
- start while in SCAN or DONE is ignored and does not queue.
- row_data, row_count and row_last are combinational from the snapshot and the index register (no extra latency). row_count is 0..section_size, zero-extended to cnt_w.
- Outputs when not in SCAN: row_valid=0, row_last=0. row_data, row_idx and row_count are 0 in IDLE.
- Reset mid-scan: the scan is abandoned, no done pulse, and the block is in IDLE the next cycle.
- Total duration with row_ready tied high: 1 + num_rows + 1 cycles from start edge to return to IDLE (done at T+num_rows+1).

Decomposition:
- Shared package holds:
  - SECTION_SIZE=19, NUM_ROWS=19, IDX_W=5, CNT_W=5
  - the state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2)
  - a row-slice helper for the flattened board layout, also used by the write-side bank.
- One sub-module is natural: row_popcount (section_size-bit input, cnt_w output, purely combinational adder tree).

Test Plan:
- Reset then idle, no start -> busy=0, row_valid=0, done=0 for 20 cycles.
- Board row r = one-hot at bit r, row_ready=1, start pulse -> 19 consecutive beats:
  - row_idx 0..18, each row_count=1, row_last only on idx 18
  - done pulse exactly 20 cycles after start edge, busy low the cycle after.
- Row 5 all ones, others zero:
  - row_ready toggled 1,0,0,1 pattern -> data held under stall
  - beat 5 row_count=19, all other counts 0, no beat duplicated or skipped.
- After start, board_in changed to all ones every cycle -> all streamed rows equal the pre-start values.
- Second start asserted during SCAN at row 7 -> ignored, exactly 19 beats and one done pulse; a start in the cycle after return to IDLE begins a fresh scan.
- rst asserted while row_idx=10 under stall -> next cycle row_valid=0, busy=0, no done. A subsequent start streams from row_idx 0.

Source files
------------

// File: rtl/marks_row_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : marks_row_reader_pkg
//  Description : Shared board geometry, FSM state encoding and the row-slice
//                helper for the flattened mark board. The write-side bank uses
//                the same helper, so both sides agree on the bit layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package marks_row_reader_pkg;

    localparam int SECTION_SIZE = 19;   // mark bits per row
    localparam int NUM_ROWS     = 19;   // rows per board
    localparam int IDX_W        = 5;    // row index width
    localparam int CNT_W        = 5;    // per-row mark count width
    localparam int BOARD_W      = NUM_ROWS * SECTION_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Row r occupies board bits r*SECTION_SIZE .. r*SECTION_SIZE+SECTION_SIZE-1.
    // Board bit r*SECTION_SIZE+k lands in slice bit k, so slice bit 0 is the
    // leftmost point of the row. Out-of-range rows read as empty.
    function automatic logic [0:SECTION_SIZE-1] row_slice(
        input logic [BOARD_W-1:0] board,
        input logic [IDX_W-1:0]   row
    );
        logic [0:SECTION_SIZE-1] s;
        s = '0;
        for (int k = 0; k < SECTION_SIZE; k++) begin
            if (int'(row) < NUM_ROWS) begin
                s[k] = board[int'(row) * SECTION_SIZE + k];
            end
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/marks_row_reader_row_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : row_popcount
//  Description : Combinational population count of one board row. Bits are
//                summed in groups of four, then the group sums are added.
//  Ports       : i_bits  [0:SECTION_SIZE-1]  row marks
//                o_count [CNT_W-1:0]         number of set marks
//  Revision    : 1.0 - initial release
// ============================================================================
module row_popcount
    import marks_row_reader_pkg::*;
(
    input  logic [0:SECTION_SIZE-1] i_bits,
    output logic [CNT_W-1:0]        o_count
);

    localparam int NUM_GRP = (SECTION_SIZE + 3) / 4;
    localparam int PAD_W   = NUM_GRP * 4;

    logic [PAD_W-1:0] w_pad;
    logic [2:0]       w_grp [NUM_GRP];

    // Pad with zeros up to a whole number of groups; bit order is irrelevant.
    assign w_pad = PAD_W'(i_bits);

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        assign w_grp[g] = 3'(w_pad[4*g])   + 3'(w_pad[4*g+1])
                        + 3'(w_pad[4*g+2]) + 3'(w_pad[4*g+3]);
    end

    always_comb begin
        o_count = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            o_count = o_count + CNT_W'(w_grp[g]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/marks_row_reader.sv
`default_nettype none
// ============================================================================
//  Module      : marks_row_reader
//  Description : Snapshots the 19x19 mark board on start and streams it out
//                one row per beat over valid/ready, with row index, last flag
//                and per-row mark count. A one-cycle done pulse follows the
//                final beat.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                start             board readout request (IDLE only)
//                board_in          flattened board
//                busy              high while a readout is in progress
//                row_valid/ready   beat handshake
//                row_data/idx/last/count  beat payload
//                done              pulse after the last beat
//  Revision    : 1.0 - initial release
// ============================================================================
module marks_row_reader
    import marks_row_reader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BOARD_W-1:0]      board_in,
    output logic                    busy,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic [0:SECTION_SIZE-1] row_data,
    output logic [IDX_W-1:0]        row_idx,
    output logic                    row_last,
    output logic [CNT_W-1:0]        row_count,
    output logic                    done
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_ROWS - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [BOARD_W-1:0]      r_snap;
    logic [IDX_W-1:0]        r_idx;

    logic                    w_in_scan;
    logic                    w_xfer;
    logic                    w_at_last;
    logic [0:SECTION_SIZE-1] w_row;
    logic [CNT_W-1:0]        w_cnt;

    assign w_in_scan = (r_state == SCAN);
    assign w_xfer    = w_in_scan & row_ready;
    assign w_at_last = (r_idx == c_last_idx);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)              w_next = SCAN;
            SCAN:    if (w_xfer & w_at_last) w_next = DONE;
            DONE:                            w_next = IDLE;
            default:                         w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_snap <= board_in;
                r_idx  <= '0;
            end else if (w_xfer && !w_at_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Payload is combinational from the snapshot and index, so it is stable
    // for as long as the index register holds under back-pressure.
    assign w_row = row_slice(r_snap, r_idx);

    row_popcount u_popcount (
        .i_bits  (w_row),
        .o_count (w_cnt)
    );

    // The index keeps its last value after a scan; payload is masked outside
    // SCAN so IDLE and DONE present zeros.
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign row_valid = w_in_scan;
    assign row_last  = w_in_scan & w_at_last;
    assign row_data  = w_in_scan ? w_row : '0;
    assign row_idx   = w_in_scan ? r_idx : '0;
    assign row_count = w_in_scan ? w_cnt : '0;

endmodule
`default_nettype wire
